// File: rtl/mod_counter.sv
// Modulo-NUM up/down counter with wrap or saturate end modes.
// Optional wrap event counter enabled by defining MOD_COUNTER_WRAPS_EN.
module mod_counter #(
  parameter int NUM    = 2048,
  parameter int WRAP_W = 8,
  localparam int W     = (NUM > 2) ? $clog2(NUM) : 1
) (
  input  logic              clk_sig,
  input  logic              reset_sig,
  input  logic              en_sig,
  input  logic              up_sig,
  input  logic              sat_sig,
  input  logic              load_sig,
  input  logic [W-1:0]      load_val,
  output logic [W-1:0]      counter_sig,
  output logic              tc_sig,
`ifdef MOD_COUNTER_WRAPS_EN
  output logic              wrap_sig,
  output logic [WRAP_W-1:0] wrap_cnt_sig
`else
  output logic              wrap_sig
`endif
);

  localparam logic [W-1:0] MAX = W'(NUM - 1);

  logic [W-1:0] r_count = '0;
  logic         r_wrap  = 1'b0;

  logic [W-1:0] w_term;
  logic [W-1:0] w_load;
  logic [W-1:0] w_next;
  logic         w_at_term;
  logic         w_wrap;

  assign w_term    = up_sig ? MAX : '0;
  assign w_at_term = (r_count == w_term);
  assign w_load    = (load_val > MAX) ? MAX : load_val;

  // Load outranks counting, so a load never produces a wrap.
  always_comb begin
    w_next = r_count;
    w_wrap = 1'b0;
    if (load_sig) begin
      w_next = w_load;
    end else if (en_sig) begin
      if (w_at_term) begin
        if (!sat_sig) begin
          w_next = up_sig ? '0 : MAX;
          w_wrap = 1'b1;
        end
      end else begin
        w_next = up_sig ? r_count + W'(1)
                        : r_count - W'(1);
      end
    end
  end

  always_ff @(posedge clk_sig) begin
    if (!reset_sig) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_wrap;
    end
  end

`ifdef MOD_COUNTER_WRAPS_EN
  logic [WRAP_W-1:0] r_wrap_cnt = '0;

  always_ff @(posedge clk_sig) begin
    if (!reset_sig) begin
      r_wrap_cnt <= '0;
    end else if (w_wrap) begin
      r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
    end
  end

  assign wrap_cnt_sig = r_wrap_cnt;
`endif

  assign counter_sig = r_count;
  assign wrap_sig    = r_wrap;
  assign tc_sig      = en_sig & w_at_term;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: NUM=5 vector table plus NUM=2 model.
// Scoreboard queue holds post-edge expectations per step.
module tb_mod_counter;

  typedef struct {
    bit       rst;
    bit       ld;
    bit       en;
    bit       up;
    bit       sat;
    bit [2:0] lv;
    int       cnt;
    bit       w;
    bit       tc;
  } vec_t;

  typedef struct {
    int cnt5;
    int w5;
    int cnt2;
    int w2;
    int wc2;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_sig = 1'b0;
  logic       load_sig = 1'b0;
  logic       en_sig = 1'b0;
  logic       up_sig = 1'b1;
  logic       sat_sig = 1'b0;
  logic [2:0] lv5 = '0;
  logic [0:0] lv2 = '0;
  logic [2:0] cnt5;
  logic [0:0] cnt2;
  logic       tc5, tc2, w5, w2;
`ifdef MOD_COUNTER_WRAPS_EN
  logic [7:0] wc5;
  logic [1:0] wc2;
`endif

  int checks = 0;
  int errors = 0;
  int m2 = 0;
  int mw = 0;
  int mwc = 0;
  vec_t tv[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  mod_counter #(.NUM(5)) u5 (
    .clk_sig(clk), .reset_sig(reset_sig),
    .en_sig(en_sig), .up_sig(up_sig),
    .sat_sig(sat_sig), .load_sig(load_sig),
    .load_val(lv5), .counter_sig(cnt5),
    .tc_sig(tc5),
`ifdef MOD_COUNTER_WRAPS_EN
    .wrap_cnt_sig(wc5),
`endif
    .wrap_sig(w5)
  );

  mod_counter #(.NUM(2), .WRAP_W(2)) u2 (
    .clk_sig(clk), .reset_sig(reset_sig),
    .en_sig(en_sig), .up_sig(up_sig),
    .sat_sig(sat_sig), .load_sig(load_sig),
    .load_val(lv2), .counter_sig(cnt2),
    .tc_sig(tc2),
`ifdef MOD_COUNTER_WRAPS_EN
    .wrap_cnt_sig(wc2),
`endif
    .wrap_sig(w2)
  );

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    bit rst, bit ld, bit en, bit up, bit sat,
    bit [2:0] lv, int cnt, bit w, bit tc);
    vec_t v;
    v.rst = rst; v.ld = ld; v.en = en;
    v.up = up; v.sat = sat; v.lv = lv;
    v.cnt = cnt; v.w = w; v.tc = tc;
    return v;
  endfunction

  task automatic step(input vec_t v);
    exp_t e;
    int term2;
    @(negedge clk);
    reset_sig = v.rst; load_sig = v.ld;
    en_sig = v.en; up_sig = v.up;
    sat_sig = v.sat; lv5 = v.lv;
    lv2 = v.lv[0];
    #1;
    term2 = v.up ? 1 : 0;
    chk("tc5", int'(tc5), int'(v.tc));
    chk("tc2", int'(tc2),
        int'(v.en && (m2 == term2)));
    mw = 0;
    if (!v.rst) begin
      m2 = 0; mwc = 0;
    end else if (v.ld) begin
      m2 = int'(v.lv[0]);
    end else if (v.en) begin
      if (m2 == term2) begin
        if (!v.sat) begin
          m2 = v.up ? 0 : 1;
          mw = 1;
          mwc = (mwc + 1) % 4;
        end
      end else begin
        m2 = v.up ? m2 + 1 : m2 - 1;
      end
    end
    e.cnt5 = v.cnt; e.w5 = int'(v.w);
    e.cnt2 = m2; e.w2 = mw; e.wc2 = mwc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("cnt5", int'(cnt5), e.cnt5);
    chk("wrap5", int'(w5), e.w5);
    chk("cnt2", int'(cnt2), e.cnt2);
    chk("wrap2", int'(w2), e.w2);
`ifdef MOD_COUNTER_WRAPS_EN
    chk("wcnt2", int'(wc2), e.wc2);
`endif
  endtask

  initial begin
    int wexp[4];
    wexp[0] = 0; wexp[1] = 1;
    wexp[2] = 0; wexp[3] = 1;
    // rst ld en up sat lv | cnt w tc
    tv.push_back(mk(0,1,1,1,0,3, 0,0,0));
    tv.push_back(mk(1,0,1,1,0,0, 1,0,0));
    tv.push_back(mk(1,0,1,1,0,0, 2,0,0));
    tv.push_back(mk(1,0,1,1,0,0, 3,0,0));
    tv.push_back(mk(1,0,1,1,0,0, 4,0,0));
    tv.push_back(mk(1,0,1,1,0,0, 0,1,1));
    tv.push_back(mk(1,0,1,1,0,0, 1,0,0));
    tv.push_back(mk(1,1,0,0,1,2, 2,0,0));
    tv.push_back(mk(1,0,1,0,1,0, 1,0,0));
    tv.push_back(mk(1,0,1,0,1,0, 0,0,0));
    tv.push_back(mk(1,0,1,0,1,0, 0,0,1));
    tv.push_back(mk(1,0,1,0,1,0, 0,0,1));
    tv.push_back(mk(1,1,1,1,0,7, 4,0,0));
    tv.push_back(mk(1,1,1,1,0,5, 4,0,1));
    tv.push_back(mk(1,0,1,0,0,0, 3,0,0));
    tv.push_back(mk(1,1,0,1,0,4, 4,0,0));
    tv.push_back(mk(1,0,1,0,0,0, 3,0,0));
    tv.push_back(mk(1,1,0,0,0,0, 0,0,0));
    tv.push_back(mk(1,0,1,0,0,0, 4,1,1));
    tv.push_back(mk(1,0,0,0,0,0, 4,0,0));
    tv.push_back(mk(1,0,1,1,1,0, 4,0,1));
    tv.push_back(mk(1,0,1,0,0,0, 3,0,0));
    tv.push_back(mk(0,1,1,0,0,2, 0,0,0));
    tv.push_back(mk(1,0,1,1,0,0, 1,0,0));
    tv.push_back(mk(1,0,1,1,0,0, 2,0,0));
    tv.push_back(mk(1,1,0,1,0,4, 4,0,0));
    tv.push_back(mk(0,0,1,1,0,0, 0,0,1));
    tv.push_back(mk(1,0,0,1,0,0, 0,0,0));

    #1;
    chk("pwrup_cnt5", int'(cnt5), 0);
    chk("pwrup_wrap5", int'(w5), 0);
    chk("pwrup_cnt2", int'(cnt2), 0);

    foreach (tv[i]) step(tv[i]);

    // NUM=2 back-to-back wraps after a fresh reset
    step(mk(0,0,0,1,0,0, 0,0,0));
    for (int i = 0; i < 4; i++) begin
      step(mk(1,0,1,1,0,0, i + 1,0,0));
      chk("b2b_wrap2", int'(w2), wexp[i]);
    end
`ifdef MOD_COUNTER_WRAPS_EN
    chk("b2b_wcnt2", int'(wc2), 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
